// File: rtl/jtframe_multicen.sv
// Fractional clock-enable generator: CH channels of num/den-rate enables plus
// half-rate companions, all gated by a lock that waits for a stable configuration.
module jtframe_multicen #(
    parameter int CH       = 4,
    parameter int W        = 10,
    parameter int LOCKW    = 8,
    parameter int LOCK_DLY = 30
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              enable,
    input  logic [CH*W-1:0]   num,
    input  logic [CH*W-1:0]   den,
    output logic [CH-1:0]     cen,
    output logic [CH-1:0]     cen2,
    output logic              locked
);

    localparam int CW = 2*CH*W;
    localparam logic [LOCKW-1:0] LOCK_LAST = LOCKW'(LOCK_DLY-1);

    logic [CW-1:0]    cfg_q, cfg_d;
    logic             cfg_change;
    logic [LOCKW-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;

    assign cfg_change = ({num, den} != cfg_q);

    // A configuration change restarts the settle count and overrides everything but rst
    always_comb begin
        cfg_d    = {num, den};
        cnt_d    = cnt_q;
        locked_d = locked_q;
        if (cfg_change) begin
            cnt_d    = '0;
            locked_d = 1'b0;
        end else if (!locked_q) begin
            if (cnt_q == LOCK_LAST) begin
                locked_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q    <= '0;
            cnt_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            cfg_q    <= cfg_d;
            cnt_q    <= cnt_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [W-1:0] num_i, den_i;
            logic [W:0]   acc_q, acc_d, sum;
            logic         phase_q, phase_d;
            logic         cen_q, cen_d, cen2_q, cen2_d;

            assign num_i = num[gi*W +: W];
            assign den_i = den[gi*W +: W];
            assign sum   = acc_q + {1'b0, num_i};

            // num>=den saturates: pulse every active cycle and keep acc pinned at 0
            always_comb begin
                acc_d   = acc_q;
                phase_d = phase_q;
                cen_d   = 1'b0;
                cen2_d  = 1'b0;
                if (cfg_change || !locked_q) begin
                    acc_d   = '0;
                    phase_d = 1'b0;
                end else if (enable) begin
                    if (sum >= {1'b0, den_i}) begin
                        acc_d   = (num_i >= den_i) ? '0 : (sum - {1'b0, den_i});
                        cen_d   = 1'b1;
                        phase_d = ~phase_q;
                        cen2_d  = phase_q;
                    end else begin
                        acc_d = sum;
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q   <= '0;
                    phase_q <= 1'b0;
                    cen_q   <= 1'b0;
                    cen2_q  <= 1'b0;
                end else begin
                    acc_q   <= acc_d;
                    phase_q <= phase_d;
                    cen_q   <= cen_d;
                    cen2_q  <= cen2_d;
                end
            end

            assign cen[gi]  = cen_q;
            assign cen2[gi] = cen2_q;
        end
    endgenerate

endmodule

// File: tb/tb_jtframe_multicen.sv
// Bench for jtframe_multicen: a pulse-count model (floor(n*num/den)) checked every
// cycle, plus directed literal patterns for lock timing, ratios, enable and reset.
module tb_jtframe_multicen;
    localparam int CH = 4, W = 10, LOCKW = 8, LOCK_DLY = 30;

    logic              rst, clk, enable;
    logic [CH*W-1:0]   num, den;
    logic [CH-1:0]     cen, cen2;
    logic              locked;

    jtframe_multicen #(.CH(CH), .W(W), .LOCKW(LOCKW), .LOCK_DLY(LOCK_DLY)) dut (
        .rst(rst), .clk(clk), .enable(enable), .num(num), .den(den),
        .cen(cen), .cen2(cen2), .locked(locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic check_en = 1'b0;

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // n = number of active edges since the accumulators last restarted;
    // pulses so far = floor(n*num/den), or n when saturated.
    logic [2*CH*W-1:0] cfg_m;
    int                since_m;
    longint            n_m   [CH];
    longint            nn_m  [CH];
    logic [1:0]        pc_m  [CH];
    logic [CH-1:0]     exp_cen, exp_cen2;
    logic              chg_m, act_m, lk_m;

    function automatic logic [1:0] pulse_calc(input longint n, input int nu, input int de);
        longint k_new, k_old;
        logic   c;
        if (nu >= de) begin
            k_new = n;
            k_old = n - 1;
        end else begin
            k_new = (n * nu) / de;
            k_old = ((n - 1) * nu) / de;
        end
        c = (k_new > k_old);
        return {c, c && (k_new % 2 == 0)};
    endfunction

    assign lk_m = (since_m >= LOCK_DLY);

    always_comb begin
        chg_m = ({num, den} != cfg_m);
        act_m = lk_m && !chg_m && enable;
        for (int i = 0; i < CH; i++) begin
            nn_m[i] = n_m[i] + (act_m ? 64'd1 : 64'd0);
            pc_m[i] = act_m ? pulse_calc(nn_m[i], int'(num[i*W +: W]), int'(den[i*W +: W])) : 2'b00;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_m    <= '0;
            since_m  <= 0;
            exp_cen  <= '0;
            exp_cen2 <= '0;
            for (int i = 0; i < CH; i++) n_m[i] <= 0;
        end else if (chg_m) begin
            cfg_m    <= {num, den};
            since_m  <= 0;
            exp_cen  <= '0;
            exp_cen2 <= '0;
            for (int i = 0; i < CH; i++) n_m[i] <= 0;
        end else begin
            if (since_m < LOCK_DLY) since_m <= since_m + 1;
            for (int i = 0; i < CH; i++) begin
                n_m[i]      <= nn_m[i];
                exp_cen[i]  <= pc_m[i][1];
                exp_cen2[i] <= pc_m[i][0];
            end
        end
    end

    always @(negedge clk) begin
        if (check_en && !rst) begin
            check("cen_model", cen, exp_cen);
            check("cen2_model", cen2, exp_cen2);
            check("locked_model", locked, lk_m);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [15:0] rec_c  [CH];
    logic [15:0] rec_c2 [CH];

    task automatic set_ch(input int i, input int n, input int d);
        num[i*W +: W] = W'(n);
        den[i*W +: W] = W'(d);
    endtask

    task automatic record(input int cycles);
        for (int i = 0; i < CH; i++) begin
            rec_c[i]  = '0;
            rec_c2[i] = '0;
        end
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            for (int i = 0; i < CH; i++) begin
                rec_c[i][k]  = cen[i];
                rec_c2[i][k] = cen2[i];
            end
        end
        $display("record %0d cycles: cen0=%h cen2_0=%h cen1=%h cen2=%h cen2_2=%h cen3=%h",
                 cycles, rec_c[0], rec_c2[0], rec_c[1], rec_c[2], rec_c2[2], rec_c[3]);
    endtask

    // Called right after new config is applied: first edge drops lock, then count relock
    task automatic wait_lock(input string nm);
        int cnt;
        @(negedge clk);
        check({nm, "_drop_locked"}, locked, 0);
        check({nm, "_drop_cen"}, cen, 0);
        cnt = 0;
        while (!locked && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check({nm, "_relock_edges"}, cnt, LOCK_DLY);
        $display("%s: relocked after %0d edges", nm, cnt);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; enable = 1'b1; num = '0; den = '0;
        repeat (3) @(negedge clk);
        check("reset_locked", locked, 0);
        check("reset_cen", cen, 0);
        check("reset_cen2", cen2, 0);

        // Reset release with constant (zero) config: lock on the 30th edge
        rst = 1'b0;
        check_en = 1'b1;
        cnt = 0;
        while (!locked && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("reset_lock_edges", cnt, LOCK_DLY);
        $display("reset release: locked after %0d edges", cnt);

        set_ch(0, 1, 4); set_ch(1, 3, 8); set_ch(2, 5, 5); set_ch(3, 0, 7);
        wait_lock("cfg1");
        record(8);
        check("ch0_1of4", rec_c[0][7:0], 8'h88);
        check("ch0_cen2", rec_c2[0][7:0], 8'h80);
        check("ch1_3of8", rec_c[1][7:0], 8'hA4);
        check("ch2_sat", rec_c[2][7:0], 8'hFF);
        check("ch2_sat_cen2", rec_c2[2][7:0], 8'hAA);
        check("ch3_num0", rec_c[3][7:0], 8'h00);
        record(8);
        check("ch1_repeat", rec_c[1][7:0], 8'hA4);
        check("ch0_repeat_cen2", rec_c2[0][7:0], 8'h80);

        // Freeze mid-count: ch0 acc=2 during the gap, resumes at the same phase
        repeat (2) @(negedge clk);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("disable_cen", cen, 0);
            check("disable_locked", locked, 1);
        end
        $display("enable low for 10 cycles");
        enable = 1'b1;
        record(8);
        check("ch0_resume", rec_c[0][7:0], 8'h22);
        check("ch0_resume_cen2", rec_c2[0][7:0], 8'h20);

        // Config change mid-run: ch0 den 4->6, ch2 den 5->0
        set_ch(0, 1, 6); set_ch(2, 5, 0);
        wait_lock("cfg2");
        record(12);
        check("ch0_1of6", rec_c[0][11:0], 12'h820);
        check("ch2_den0", rec_c[2][11:0], 12'hFFF);
        check("ch2_den0_cen2", rec_c2[2][11:0], 12'hAAA);

        // Asynchronous reset pulse between clock edges
        @(negedge clk);
        check("pre_rst_cen2ch", cen[2], 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cen", cen, 0);
        check("async_rst_cen2", cen2, 0);
        check("async_rst_locked", locked, 0);
        $display("async reset pulse applied");
        #1 rst = 1'b0;
        wait_lock("post_rst");
        record(8);
        check("post_rst_ch1", rec_c[1][7:0], 8'hA4);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
